icache_fetch_responder: RTL and testbench
=========================================

# icache_fetch_responder

- Responder end of the fetch-stage → icache request interface.
- Accepts `req_cpu_icache_t`-style requests, serves them from a single-line fetch buffer, refills that line from the memory side on a miss, and returns one 32-bit instruction per accepted request.
- Sits between `if_stage_1` and the L2/memory port; owns the fetch buffer that `invalidate_buffer` / `inval_fetch` refer to.

## Interface
Parameters:
- `LINE_BYTES`, 16: refill line size in bytes; power of two, ≥ 8.
- `VADDR_W`, 40: request address width.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rstn_i` in 1: reset. Synchronous, active-low.
- `req_valid_i` in 1: fetch request valid.
- `req_vaddr_i` in `VADDR_W`: fetch address; bits [1:0] are always 0.
- `req_invalidate_icache_i` in 1: invalidate the whole icache.
- `req_invalidate_buffer_i` in 1: invalidate the fetch buffer.
- `req_inval_fetch_i` in 1: kill the in-flight fetch.
- `resp_valid_o` out 1: instruction response valid (1-cycle pulse).
- `resp_inst_o` out 32: instruction word.
- `resp_vaddr_o` out `VADDR_W`: address of the returned instruction.
- `resp_xcpt_o` out 1: access fault on refill; `resp_inst_o` = 0 when set.
- `busy_o` out 1: refill in progress; requests are ignored while high.
- `mem_req_valid_o` out 1: line refill request.
- `mem_req_addr_o` out `VADDR_W`: line-aligned refill address.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_resp_valid_i` in 1: refill data valid.
- `mem_resp_data_i` in `LINE_BYTES*8`: refill line data.
- `mem_resp_error_i` in 1: refill bus error; qualified by `mem_resp_valid_i`.
- `inval_icache_o` out 1: one-cycle invalidate pulse to the icache array.

## Operation
- **Buffer state:** `buf_valid`, `buf_tag` = `vaddr[VADDR_W-1:log2(LINE_BYTES)]`, `buf_data` (one line).
- **Word select:** `vaddr[log2(LINE_BYTES)-1:2]`; word 0 is `data[31:0]`, little-endian.
- **FSM states:** IDLE, REQ, WAIT, DRAIN.
- **IDLE:**
  - A request is accepted only in IDLE.
  - **Hit:** `buf_valid` && tag match && no buffer invalidation this cycle. Register the response; stay in IDLE.
  - **Miss:** latch the address; go to REQ.
- **REQ:**
  - `mem_req_valid_o` = 1 and `mem_req_addr_o` stay stable until `mem_req_ready_i`.
  - On handshake: go to WAIT, or to DRAIN if the kill flag is set.
- **WAIT:**
  - On `mem_resp_valid_i` without error: fill the buffer, set `buf_valid`, register the response, go to IDLE.
  - On error: `resp_xcpt_o` = 1, `buf_valid` = 0, go to IDLE.
- **DRAIN:** on `mem_resp_valid_i`, discard the data, leave the buffer unchanged, emit no response, go to IDLE.
- **Kill:**
  - `req_inval_fetch_i` in REQ sets the kill flag; the handshake still completes.
  - In WAIT it goes directly to DRAIN.
  - In IDLE it acts as a buffer invalidation.
- **Invalidation:**
  - `req_invalidate_buffer_i` or `req_inval_fetch_i` clears `buf_valid` in any state.
  - In IDLE, a simultaneous `req_valid_i` is treated as a miss, never a hit on stale data.
  - `req_invalidate_icache_i` clears `buf_valid` and pulses `inval_icache_o` on the next cycle, in any state.
- **`busy_o`:** `busy_o` = (state != IDLE). Requests arriving while busy are dropped; the fetch stage holds its PC, so they are re-presented.
- **Reset** (applies mid-refill too): state IDLE, `buf_valid` = 0, kill flag = 0, and all outputs 0. A memory response arriving after reset in IDLE is ignored.

## Timing
- **Hit:** request in cycle N → `resp_valid_o` in N+1.
- **Miss:**
  - Request in N → `mem_req_valid_o` from N+1.
  - Handshake in H → WAIT from H+1.
  - Response in M → `resp_valid_o` in M+1.
  - Earliest back-to-back request accepted in M+1.
- **Response outputs:** `resp_*` are registered; `resp_valid_o` is high for exactly one cycle per non-killed accepted request.
- **Memory inputs:** `mem_resp_valid_i` is ignored in IDLE and REQ.

## Configuration
- **`ICACHE_FETCH_RESP_PERF_EN`** defined:
  - Adds 32-bit outputs `perf_hit_cnt_o` and `perf_miss_cnt_o`.
  - They count accepted hits and accepted misses, wrap at 2^32, and reset to 0.
  - Killed misses still count as misses.
- **Undefined:** the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Cold miss:**
  - Stimulus: reset, request vaddr `0x80000004`; memory ready immediately, data returned 3 cycles later with word1 = `0x00000013`.
  - Required: `mem_req_addr_o` = `0x80000000`; `resp_inst_o` = `0x00000013`, `resp_xcpt_o` = 0.
- **Hit:** then request `0x8000000C` → response next cycle with word3; no `mem_req_valid_o`.
- **Invalidate with same-line request:** `req_invalidate_buffer_i` together with a request to `0x80000008` → treated as a miss; a new refill is issued.
- **Kill in WAIT:** `req_inval_fetch_i` in WAIT → memory response discarded, no `resp_valid_o`; the next request to the same line misses.
- **Bus error:** refill with `mem_resp_error_i` = 1 → `resp_xcpt_o` = 1, `resp_inst_o` = 0; a retry of the same address misses.
- **Reset mid-refill:** `rstn_i` low in REQ → next cycle all outputs 0 and state IDLE; a late `mem_resp_valid_i` produces no response.

Source files
------------

// File: rtl/icache_fetch_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_fetch_responder: single-line fetch buffer answering fetch-stage   |
// | requests; refills the line from memory on a miss.                        |
// | Optional: ICACHE_FETCH_RESP_PERF_EN adds hit/miss counters.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module icache_fetch_responder #(
  parameter int LINE_BYTES = 16,
  parameter int VADDR_W    = 40
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    req_valid_i,
  input  logic [VADDR_W-1:0]      req_vaddr_i,
  input  logic                    req_invalidate_icache_i,
  input  logic                    req_invalidate_buffer_i,
  input  logic                    req_inval_fetch_i,
  output logic                    resp_valid_o,
  output logic [31:0]             resp_inst_o,
  output logic [VADDR_W-1:0]      resp_vaddr_o,
  output logic                    resp_xcpt_o,
  output logic                    busy_o,
  output logic                    mem_req_valid_o,
  output logic [VADDR_W-1:0]      mem_req_addr_o,
  input  logic                    mem_req_ready_i,
  input  logic                    mem_resp_valid_i,
  input  logic [LINE_BYTES*8-1:0] mem_resp_data_i,
  input  logic                    mem_resp_error_i,
  output logic                    inval_icache_o
`ifdef ICACHE_FETCH_RESP_PERF_EN
  ,
  output logic [31:0]             perf_hit_cnt_o,
  output logic [31:0]             perf_miss_cnt_o
`endif
);

  localparam int c_off_w  = $clog2(LINE_BYTES);
  localparam int c_word_w = c_off_w - 2;
  localparam int c_tag_w  = VADDR_W - c_off_w;
  localparam int c_words  = LINE_BYTES / 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_kill, w_kill_nxt;
  logic                    r_buf_valid;
  logic [c_tag_w-1:0]      r_buf_tag;
  logic [LINE_BYTES*8-1:0] r_buf_data;
  logic [c_tag_w-1:0]      r_req_tag;
  logic [c_word_w-1:0]     r_req_word;
  logic                    r_resp_valid;
  logic                    r_resp_xcpt;
  logic [31:0]             r_resp_inst;
  logic [VADDR_W-1:0]      r_resp_vaddr;
  logic                    r_inval_icache;

  logic [c_tag_w-1:0]      w_req_tag;
  logic [c_word_w-1:0]     w_req_word;
  logic                    w_buf_inval, w_hit, w_miss, w_fill, w_err;
  logic [31:0]             w_hit_inst, w_fill_inst;
  logic                    w_unused_low_bits;

  assign w_req_tag         = req_vaddr_i[VADDR_W-1:c_off_w];
  assign w_req_word        = req_vaddr_i[c_off_w-1:2];
  assign w_unused_low_bits = ^req_vaddr_i[1:0];

  // Any invalidation in the request cycle forbids a hit on the old line.
  assign w_buf_inval = req_invalidate_buffer_i | req_inval_fetch_i | req_invalidate_icache_i;
  assign w_hit  = (r_state == S_IDLE) & req_valid_i & r_buf_valid &
                  (r_buf_tag == w_req_tag) & ~w_buf_inval;
  assign w_miss = (r_state == S_IDLE) & req_valid_i & ~w_hit;
  assign w_fill = (r_state == S_WAIT) & mem_resp_valid_i & ~mem_resp_error_i & ~req_inval_fetch_i;
  assign w_err  = (r_state == S_WAIT) & mem_resp_valid_i &  mem_resp_error_i & ~req_inval_fetch_i;

  always_comb begin
    w_hit_inst  = '0;
    w_fill_inst = '0;
    for (int i = 0; i < c_words; i++) begin
      if (w_req_word == i[c_word_w-1:0]) w_hit_inst  = r_buf_data[i*32 +: 32];
      if (r_req_word == i[c_word_w-1:0]) w_fill_inst = mem_resp_data_i[i*32 +: 32];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_state_nxt = S_REQ;
          w_kill_nxt  = 1'b0;
        end
      end
      S_REQ: begin
        if (req_inval_fetch_i) w_kill_nxt = 1'b1;
        if (mem_req_ready_i) begin
          w_state_nxt = (r_kill | req_inval_fetch_i) ? S_DRAIN : S_WAIT;
          w_kill_nxt  = 1'b0;
        end
      end
      // A kill arriving with the response simply discards it.
      S_WAIT: begin
        if (mem_resp_valid_i)       w_state_nxt = S_IDLE;
        else if (req_inval_fetch_i) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (mem_resp_valid_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state        <= S_IDLE;
      r_kill         <= 1'b0;
      r_buf_valid    <= 1'b0;
      r_buf_tag      <= '0;
      r_req_tag      <= '0;
      r_req_word     <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_xcpt    <= 1'b0;
      r_resp_inst    <= '0;
      r_resp_vaddr   <= '0;
      r_inval_icache <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_kill         <= w_kill_nxt;
      r_resp_valid   <= w_hit | w_fill | w_err;
      r_inval_icache <= req_invalidate_icache_i;
      if (w_miss) begin
        r_req_tag  <= w_req_tag;
        r_req_word <= w_req_word;
      end
      if (w_hit) begin
        r_resp_inst  <= w_hit_inst;
        r_resp_vaddr <= req_vaddr_i;
        r_resp_xcpt  <= 1'b0;
      end else if (w_fill | w_err) begin
        r_resp_inst  <= w_err ? 32'h0 : w_fill_inst;
        r_resp_vaddr <= {r_req_tag, r_req_word, 2'b00};
        r_resp_xcpt  <= w_err;
      end
      if (w_fill) r_buf_tag <= r_req_tag;
      // Invalidation wins over a same-cycle fill.
      if (w_buf_inval | w_err) r_buf_valid <= 1'b0;
      else if (w_fill)         r_buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fill) r_buf_data <= mem_resp_data_i;
  end

`ifdef ICACHE_FETCH_RESP_PERF_EN
  logic [31:0] r_perf_hit_cnt, r_perf_miss_cnt;
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_perf_hit_cnt  <= '0;
      r_perf_miss_cnt <= '0;
    end else begin
      if (w_hit)  r_perf_hit_cnt  <= r_perf_hit_cnt + 32'd1;
      if (w_miss) r_perf_miss_cnt <= r_perf_miss_cnt + 32'd1;
    end
  end
  assign perf_hit_cnt_o  = r_perf_hit_cnt;
  assign perf_miss_cnt_o = r_perf_miss_cnt;
`endif

  assign resp_valid_o    = r_resp_valid;
  assign resp_inst_o     = r_resp_inst;
  assign resp_vaddr_o    = r_resp_vaddr;
  assign resp_xcpt_o     = r_resp_xcpt;
  assign busy_o          = (r_state != S_IDLE);
  assign mem_req_valid_o = (r_state == S_REQ);
  assign mem_req_addr_o  = (r_state == S_REQ) ? {r_req_tag, {c_off_w{1'b0}}} : '0;
  assign inval_icache_o  = r_inval_icache;

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_icache_fetch_responder: directed and randomized checks of the fetch   |
// | responder against a line-buffer reference model.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_icache_fetch_responder;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid, req_inv_icache, req_inv_buffer, req_inval_fetch;
  logic [39:0]  req_vaddr;
  logic         resp_valid, resp_xcpt, busy, mem_req_valid, inval_icache;
  logic [31:0]  resp_inst;
  logic [39:0]  resp_vaddr, mem_req_addr;
  logic         mem_req_ready, mem_resp_valid, mem_resp_error;
  logic [127:0] mem_resp_data;
`ifdef ICACHE_FETCH_RESP_PERF_EN
  logic [31:0]  perf_hit, perf_miss;
`endif

  icache_fetch_responder #(.LINE_BYTES(16), .VADDR_W(40)) dut (
    .clk_i                   (clk),
    .rstn_i                  (rstn),
    .req_valid_i             (req_valid),
    .req_vaddr_i             (req_vaddr),
    .req_invalidate_icache_i (req_inv_icache),
    .req_invalidate_buffer_i (req_inv_buffer),
    .req_inval_fetch_i       (req_inval_fetch),
    .resp_valid_o            (resp_valid),
    .resp_inst_o             (resp_inst),
    .resp_vaddr_o            (resp_vaddr),
    .resp_xcpt_o             (resp_xcpt),
    .busy_o                  (busy),
    .mem_req_valid_o         (mem_req_valid),
    .mem_req_addr_o          (mem_req_addr),
    .mem_req_ready_i         (mem_req_ready),
    .mem_resp_valid_i        (mem_resp_valid),
    .mem_resp_data_i         (mem_resp_data),
    .mem_resp_error_i        (mem_resp_error),
    .inval_icache_o          (inval_icache)
`ifdef ICACHE_FETCH_RESP_PERF_EN
    ,
    .perf_hit_cnt_o          (perf_hit),
    .perf_miss_cnt_o         (perf_miss)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  // Reference model: which line (if any) the fetch buffer currently holds.
  bit          m_valid = 1'b0;
  logic [35:0] m_line  = '0;
  int          m_hits  = 0;
  int          m_misses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [39:0] a);
    if (a == 40'h80000004) return 32'h00000013;
    return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [127:0] mem_line(input logic [39:0] a);
    logic [127:0] l;
    logic [39:0]  base;
    base = {a[39:4], 4'h0};
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem_word(base + 40'(i * 4));
    return l;
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0; req_inv_icache = 1'b0; req_inv_buffer = 1'b0; req_inval_fetch = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_error = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
    chk({tag, "_resp_inst"},  64'(resp_inst),  64'h0);
    chk({tag, "_resp_vaddr"}, 64'(resp_vaddr), 64'h0);
    chk({tag, "_resp_xcpt"},  64'(resp_xcpt),  64'h0);
    chk({tag, "_busy"},       64'(busy),       64'h0);
    chk({tag, "_mreq_valid"}, 64'(mem_req_valid), 64'h0);
    chk({tag, "_mreq_addr"},  64'(mem_req_addr),  64'h0);
    chk({tag, "_inval_ic"},   64'(inval_icache),  64'h0);
  endtask

  // inv: 0 none, 1 invalidate_buffer, 2 inval_fetch alongside the request.
  // kill: 0 none, 1 kill while in REQ, 2 kill while in WAIT.
  task automatic transact(input logic [39:0] a, input int inv, input int kill, input bit err,
                          input int rdy_dly, input int rsp_dly);
    bit hit;
    hit = m_valid && (m_line == a[39:4]) && (inv == 0);
    if (kill == 1 && rdy_dly == 0) rdy_dly = 1;
    if (kill == 2 && rsp_dly == 0) rsp_dly = 1;
    req_valid = 1'b1; req_vaddr = a;
    req_inv_buffer = (inv == 1); req_inval_fetch = (inv == 2);
    @(negedge clk);
    idle_inputs();
    req_vaddr = {8'h0, $urandom()} & 40'hFFFFFFFFFC;
    if (inv != 0) m_valid = 1'b0;
    if (hit) begin
      m_hits++;
      chk("hit_valid", 64'(resp_valid), 64'h1);
      chk("hit_inst",  64'(resp_inst),  64'(mem_word(a)));
      chk("hit_vaddr", 64'(resp_vaddr), 64'(a));
      chk("hit_xcpt",  64'(resp_xcpt),  64'h0);
      chk("hit_no_mreq", 64'(mem_req_valid), 64'h0);
      chk("hit_busy",  64'(busy), 64'h0);
      return;
    end
    m_misses++;
    chk("miss_no_resp", 64'(resp_valid), 64'h0);
    chk("miss_busy", 64'(busy), 64'h1);
    chk("miss_mreq_valid", 64'(mem_req_valid), 64'h1);
    chk("miss_mreq_addr", 64'(mem_req_addr), 64'({a[39:4], 4'h0}));
    for (int i = 0; i < rdy_dly; i++) begin
      req_valid = 1'b1;
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_inval_fetch = (kill == 1 && i == 0);
      @(negedge clk);
      idle_inputs();
      if (kill == 1 && i == 0) m_valid = 1'b0;
      chk("req_hold_valid", 64'(mem_req_valid), 64'h1);
      chk("req_hold_addr", 64'(mem_req_addr), 64'({a[39:4], 4'h0}));
      chk("req_no_resp", 64'(resp_valid), 64'h0);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("hs_mreq_drop", 64'(mem_req_valid), 64'h0);
    chk("hs_busy", 64'(busy), 64'h1);
    for (int i = 0; i < rsp_dly; i++) begin
      req_valid = 1'b1;
      req_inval_fetch = (kill == 2 && i == 0);
      @(negedge clk);
      idle_inputs();
      if (kill == 2 && i == 0) m_valid = 1'b0;
      chk("wait_no_resp", 64'(resp_valid), 64'h0);
      chk("wait_busy", 64'(busy), 64'h1);
    end
    mem_resp_valid = 1'b1; mem_resp_data = mem_line(a); mem_resp_error = err;
    @(negedge clk);
    idle_inputs();
    chk("done_busy", 64'(busy), 64'h0);
    if (kill != 0) begin
      chk("kill_no_resp", 64'(resp_valid), 64'h0);
    end else if (err) begin
      m_valid = 1'b0;
      chk("err_valid", 64'(resp_valid), 64'h1);
      chk("err_xcpt",  64'(resp_xcpt),  64'h1);
      chk("err_inst",  64'(resp_inst),  64'h0);
      chk("err_vaddr", 64'(resp_vaddr), 64'(a));
    end else begin
      m_valid = 1'b1; m_line = a[39:4];
      chk("fill_valid", 64'(resp_valid), 64'h1);
      chk("fill_inst",  64'(resp_inst),  64'(mem_word(a)));
      chk("fill_vaddr", 64'(resp_vaddr), 64'(a));
      chk("fill_xcpt",  64'(resp_xcpt),  64'h0);
    end
    if ($urandom_range(0, 1) == 1) begin
      @(negedge clk);
      chk("resp_pulse", 64'(resp_valid), 64'h0);
    end
  endtask

  task automatic icache_inval();
    req_inv_icache = 1'b1;
    @(negedge clk);
    req_inv_icache = 1'b0;
    m_valid = 1'b0;
    chk("inval_ic_pulse", 64'(inval_icache), 64'h1);
    @(negedge clk);
    chk("inval_ic_clear", 64'(inval_icache), 64'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] a;
    idle_inputs();
    req_vaddr = '0; mem_resp_data = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;

    transact(40'h80000004, 0, 0, 1'b0, 0, 3);   // cold miss, word1 = 0x13
    transact(40'h8000000C, 0, 0, 1'b0, 0, 0);   // hit, word3
    transact(40'h80000008, 1, 0, 1'b0, 1, 1);   // invalidate + same-line request
    transact(40'h80000010, 0, 2, 1'b0, 0, 2);   // kill in WAIT
    transact(40'h80000014, 0, 0, 1'b0, 0, 1);   // same line now misses
    transact(40'h80000018, 0, 0, 1'b0, 0, 0);   // hit on refilled line
    transact(40'h80000020, 0, 1, 1'b0, 2, 1);   // kill in REQ
    transact(40'h80000024, 0, 0, 1'b1, 1, 2);   // bus error
    transact(40'h80000024, 0, 0, 1'b0, 0, 1);   // retry misses
    transact(40'h80000028, 2, 0, 1'b0, 0, 0);   // inval_fetch in IDLE forces miss
    transact(40'h8000002C, 0, 0, 1'b0, 0, 0);   // hit
    icache_inval();
    transact(40'h8000002C, 0, 0, 1'b0, 0, 0);   // miss after icache invalidation

`ifdef ICACHE_FETCH_RESP_PERF_EN
    chk("perf_hit",  64'(perf_hit),  64'(m_hits));
    chk("perf_miss", 64'(perf_miss), 64'(m_misses));
`endif

    // Reset in the middle of a refill, then a late memory response.
    req_valid = 1'b1; req_vaddr = 40'h80000030;
    @(negedge clk);
    idle_inputs();
    chk("rst_mid_mreq", 64'(mem_req_valid), 64'h1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    m_valid = 1'b0; m_hits = 0; m_misses = 0;
    chk_all_zero("rst_mid");
    mem_resp_valid = 1'b1; mem_resp_data = mem_line(40'h80000030);
    @(negedge clk);
    idle_inputs();
    chk("late_resp_ignored", 64'(resp_valid), 64'h0);
    chk("late_resp_busy", 64'(busy), 64'h0);
    transact(40'h80000030, 0, 0, 1'b0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      int inv, kill;
      bit err;
      a    = 40'h80000000 + 40'($urandom_range(0, 47) * 4);
      inv  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      kill = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      err  = ($urandom_range(0, 7) == 0);
      transact(a, inv, kill, err, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) icache_inval();
    end

`ifdef ICACHE_FETCH_RESP_PERF_EN
    chk("perf_hit_end",  64'(perf_hit),  64'(m_hits));
    chk("perf_miss_end", 64'(perf_miss), 64'(m_misses));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
